// File: rtl/friscv_pkg.sv
// Shared FRiscV constants and types.
// Holds the data-memory access encodings and the responder FSM states.
package friscv_pkg;

    localparam int XLEN             = 32;
    localparam int DMEM_DEPTH_BYTES = 4096;
    localparam int DMEM_ADDR_WIDTH  = $clog2(DMEM_DEPTH_BYTES);

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_MERGE,
        S_RESP
    } dmem_resp_state_e;

    // Size 2'b11 is never legal; halves and words must be naturally aligned.
    function automatic logic dmem_access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            MEM_BYTE: err = 1'b0;
            MEM_HALF: err = addr_lo[0];
            MEM_WORD: err = |addr_lo;
            default:  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/friscv_mem_align.sv
// Lane formatting for the data-memory responder: load extraction with
// sign/zero extension and read-modify-write merge for sub-word stores.
module friscv_mem_align
    import friscv_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merge_data
);

    logic [4:0]      shift;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] mask;

    always_comb begin
        shift     = 5'd0;
        mask      = '0;
        load_data = '0;
        case (size)
            MEM_BYTE: begin
                shift = {addr_lo, 3'b000};
                mask  = 32'h0000_00FF << shift;
            end
            MEM_HALF: begin
                shift = {addr_lo[1], 4'b0000};
                mask  = 32'h0000_FFFF << shift;
            end
            MEM_WORD: mask = '1;
            default:  mask = '0;
        endcase

        lane = rdata >> shift;
        case (size)
            MEM_BYTE: load_data = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
            MEM_HALF: load_data = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
            MEM_WORD: load_data = rdata;
            default:  load_data = '0;
        endcase

        // Only the addressed lane changes; the rest of the old word is kept.
        merge_data = (rdata & ~mask) | ((wdata << shift) & mask);
    end

endmodule

// File: rtl/friscv_dmem_resp.sv
// Data-memory responder: valid/ready request in, single-port RAM access,
// one-cycle response pulse out. Sub-word stores read the word first.
module friscv_dmem_resp
    import friscv_pkg::*;
#(
    parameter int DEPTH_BYTES = DMEM_DEPTH_BYTES,
    parameter int ADDR_WIDTH  = $clog2(DEPTH_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [XLEN-1:0]       req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [XLEN-1:0]       rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-3:0] ram_addr_o,
    output logic [XLEN-1:0]       ram_wdata_o,
    input  logic [XLEN-1:0]       ram_rdata_i
);

    dmem_resp_state_e      state;
    logic                  we_q;
    logic                  uns_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [XLEN-1:0]       rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  accept;
    logic                  req_err;
    logic [XLEN-1:0]       load_data;
    logic [XLEN-1:0]       merge_data;

    assign accept  = req_valid_i & req_ready_o;
    assign req_err = dmem_access_err(req_size_i, req_addr_i[1:0]);

    assign req_ready_o = (state == S_IDLE) || (state == S_RESP);
    assign rsp_valid_o = (state == S_RESP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign ram_en_o    = (state == S_READ) || (state == S_MERGE);
    assign ram_we_o    = (state == S_MERGE);
    assign ram_addr_o  = addr_q[ADDR_WIDTH-1:2];
    // The merge uses read data that only arrives in the MERGE cycle itself.
    assign ram_wdata_o = (state != S_MERGE)    ? '0 :
                         (size_q == MEM_WORD)  ? wdata_q : merge_data;

    friscv_mem_align u_align (
        .rdata       (ram_rdata_i),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_RESP: begin
                    rsp_rdata_q <= '0;
                    if (accept) begin
                        we_q      <= req_we_i;
                        uns_q     <= req_unsigned_i;
                        size_q    <= req_size_i;
                        addr_q    <= req_addr_i;
                        wdata_q   <= req_wdata_i;
                        rsp_err_q <= req_err;
                        if (req_err)
                            state <= S_RESP;
                        else if (req_we_i && (req_size_i == MEM_WORD))
                            state <= S_MERGE;
                        else
                            state <= S_READ;
                    end else begin
                        rsp_err_q <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_READ:    state <= we_q ? S_MERGE : S_CAPTURE;
                S_CAPTURE: begin
                    rsp_rdata_q <= load_data;
                    state       <= S_RESP;
                end
                S_MERGE:   state <= S_RESP;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_friscv_dmem_resp.sv
// Bench for friscv_dmem_resp: directed vector table, error/back-to-back/reset
// sequences, then random traffic against a byte-array reference model.
module tb_friscv_dmem_resp;
    import friscv_pkg::*;

    localparam int AW = DMEM_ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [1:0]    req_size_i;
    logic [AW-1:0] req_addr_i;
    logic [31:0]   req_wdata_i;
    logic          rsp_valid_o, rsp_err_o, ram_en_o, ram_we_o;
    logic [31:0]   rsp_rdata_o, ram_wdata_o, ram_rdata_i;
    logic [AW-3:0] ram_addr_o;

    always #5 clk = ~clk;

    friscv_dmem_resp dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .ram_en_o       (ram_en_o),
        .ram_we_o       (ram_we_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_rdata_i    (ram_rdata_i)
    );

    // Synchronous single-port RAM: read data appears the cycle after enable.
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) ram[ram_addr_o] <= ram_wdata_o;
            else          ram_rdata_i     <= ram[ram_addr_o];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t expq[$];
    exp_t mon_e;

    logic [7:0] ref_mem [0:4095];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_en_o) en_cnt++;
        if (rst_n && rsp_valid_o) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got response at cycle %0d expected none", cyc);
            end else begin
                mon_e = expq.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
                chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, mon_e.err});
            end
        end
    end

    // Reference model: byte-addressed memory, little-endian, latency by access class.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [AW-1:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic err, output int lat);
        int          n;
        logic [63:0] v;
        rd  = '0;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        lat = 1;
        if (err) return;
        n = 1 << size;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            lat = (n == 4) ? 2 : 3;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
            if (!uns && n < 4 && v[8*n-1]) v = v - (64'd1 << (8*n));
            rd  = v[31:0];
            lat = 3;
        end
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic use_tab, input logic [31:0] t_rd, input logic t_err,
                         output int acc);
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic        rdy;
        int          tries;
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        tries = 0;
        do begin
            @(negedge clk);
            rdy = req_ready_o;
            tries++;
        end while (!rdy && tries < 10);
        acc = cyc;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready stayed %b expected 1 at cycle %0d", rdy, cyc);
            req_valid_i = 1'b0;
            return;
        end
        model(we, size, uns, addr, wdata, rd, err, lat);
        if (use_tab) begin
            rd  = t_rd;
            err = t_err;
        end
        expq.push_back('{acc + lat, rd, err});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        req_valid_i = 1'b0;
        while (expq.size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding expected 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},  {31'b0, req_ready_o}, 32'd1);
        chk({tag, "_valid"},  {31'b0, rsp_valid_o}, 32'd0);
        chk({tag, "_rdata"},  rsp_rdata_o, 32'd0);
        chk({tag, "_err"},    {31'b0, rsp_err_o}, 32'd0);
        chk({tag, "_ram_en"}, {31'b0, ram_en_o}, 32'd0);
        chk({tag, "_ram_we"}, {31'b0, ram_we_o}, 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr_o), 32'd0);
        chk({tag, "_ram_wdata"}, ram_wdata_o, 32'd0);
    endtask

    typedef struct {
        logic          we;
        logic [1:0]    size;
        logic          uns;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   rd;
        logic          err;
    } vec_t;
    vec_t tab[11];

    int acc;
    int acc_b2b[4];
    int snap;

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        ram_rdata_i    = '0;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = '0;
        req_wdata_i    = '0;

        tab[0]  = '{1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0,        1'b0};
        tab[1]  = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        tab[2]  = '{1'b1, 2'd2, 1'b0, 12'h010, 32'h11223344, 32'h0,        1'b0};
        tab[3]  = '{1'b1, 2'd0, 1'b0, 12'h013, 32'hFFFFFF80, 32'h0,        1'b0};
        tab[4]  = '{1'b0, 2'd0, 1'b0, 12'h013, 32'h0,        32'hFFFFFF80, 1'b0};
        tab[5]  = '{1'b0, 2'd0, 1'b1, 12'h013, 32'h0,        32'h00000080, 1'b0};
        tab[6]  = '{1'b1, 2'd1, 1'b0, 12'h022, 32'h1234ABCD, 32'h0,        1'b0};
        tab[7]  = '{1'b0, 2'd1, 1'b0, 12'h022, 32'h0,        32'hFFFFABCD, 1'b0};
        tab[8]  = '{1'b0, 2'd2, 1'b1, 12'h010, 32'h0,        32'h80223344, 1'b0};
        tab[9]  = '{1'b0, 2'd1, 1'b1, 12'h012, 32'h0,        32'h00008022, 1'b0};
        tab[10] = '{1'b0, 2'd0, 1'b0, 12'h010, 32'h0,        32'h00000044, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 11; i++)
            issue(tab[i].we, tab[i].size, tab[i].uns, tab[i].addr, tab[i].wdata,
                  1'b1, tab[i].rd, tab[i].err, acc);
        drain();
        chk("ram_word4", ram[4], 32'h80223344);
        chk("ram_word8", ram[8], 32'hABCD0000);

        snap = en_cnt;
        issue(1'b0, 2'd1, 1'b0, 12'h001, 32'h0,        1'b1, 32'h0, 1'b1, acc);
        issue(1'b1, 2'd2, 1'b0, 12'h006, 32'h12345678, 1'b1, 32'h0, 1'b1, acc);
        issue(1'b0, 2'd3, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0, 1'b1, acc);
        drain();
        chk("err_no_ram_en", 32'(en_cnt), 32'(snap));
        chk("err_no_write", ram[1], 32'h0);

        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] a;
            a = (i % 2 == 0) ? 12'h010 : 12'h022;
            issue(1'b0, 2'(2 - i % 3), i[0], a, 32'h0, 1'b0, 32'h0, 1'b0, acc_b2b[i]);
        end
        for (int i = 1; i < 4; i++)
            chk("b2b_accept", 32'(acc_b2b[i]), 32'(acc_b2b[i-1] + 3));
        drain();

        issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1'b1, 32'h80223344, 1'b0, acc);
        rst_n = 1'b0;
        expq.delete();
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        idle(4);
        issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1'b1, 32'h80223344, 1'b0, acc);
        drain();

        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 255)), $urandom, 1'b0, 32'h0, 1'b0, acc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        drain();
        for (int w = 0; w < 64; w++)
            chk("ram_vs_model", ram[w],
                {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/friscv_dmem_resp.md
# friscv_dmem_resp

Data-memory responder for the FRiscV pipelined core. Accepts load/store requests from the MEM stage over a valid/ready handshake, drives the word-addressed single-port data RAM, and returns a single-cycle response. It implements byte, halfword and word accesses:

- Loads are sign- or zero-extended.
- Sub-word stores use read-modify-write.
- Misaligned or illegal sizes are flagged as errors without touching the RAM.

## Interface
- XLEN, 32, data word width (package XLEN)
- DEPTH_BYTES, 4096, data memory size in bytes (package DMEM_DEPTH_BYTES)
- ADDR_WIDTH, $clog2(DEPTH_BYTES), byte-address width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept; transfer when valid & ready
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  load zero-extends when 1 (LBU/LHU)
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wdata_i  in  XLEN  store data, right-aligned
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure
- rsp_rdata_o  out  XLEN  formatted load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned/illegal access, valid with rsp_valid_o
- ram_en_o  out  1  RAM access enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_WIDTH-2  word address = addr[ADDR_WIDTH-1:2]
- ram_wdata_o  out  XLEN  full word to write
- ram_rdata_i  in  XLEN  read data, valid the cycle after a read-enable cycle

## Operation
- **FSM states:** IDLE, READ, CAPTURE, MERGE, RESP.
- **Ready:** req_ready_o = 1 in IDLE and RESP, 0 otherwise. A request accepted in RESP overlaps that response.
- **Registering:** on accept, the request is registered and the next state is chosen:
  - error → RESP
  - word store → MERGE
  - load or sub-word store → READ
- **Error:** size 11; half with addr[0]=1; word with addr[1:0]≠0. Sets rsp_err_o=1, rsp_rdata_o=0, with no RAM access.
- **READ:** ram_en_o=1, ram_we_o=0. Next state is CAPTURE (load) or MERGE (sub-word store).
- **CAPTURE:** extracts the addressed lane from ram_rdata_i into the response register, then goes to RESP.
  - Little-endian lane selection: byte = addr[1:0]·8, half = addr[1]·16.
  - Bit 7/15 is replicated unless req_unsigned_i was 1; word loads are passed through.
- **MERGE:** ram_en_o=1, ram_we_o=1, then RESP.
  - Word store: ram_wdata_o = wdata.
  - Sub-word store: ram_wdata_o = ram_rdata_i with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
- **RESP:** rsp_valid_o=1 for exactly one cycle. Next state: accept → per the rule above; otherwise IDLE.
- **RAM outputs:** ram_en_o=0 and ram_we_o=0 in every state other than READ and MERGE.

## Timing
- Request accepted at cycle T. rsp_valid_o is asserted at:
  - error: T+1
  - word store: T+2 (RAM write at T+1)
  - load: T+3 (read T+1, capture T+2)
  - sub-word store: T+3 (read T+1, write T+2)
- Back-to-back: the next request is accepted in the RESP cycle, with no idle gap.
- **Reset values** (clocked while rst_n=0): state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, all request registers 0.
- **Reset mid-operation:** the in-flight request is dropped with no response. A MERGE write already presented in the reset cycle is not suppressed by the responder.
- **Ignored inputs:** req_* inputs are ignored when req_ready_o=0. req_unsigned_i is ignored for stores and word loads.

## Structure
- **Package additions to friscv_pkg:**
  - MEM_SIZE enum: MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10.
  - DMEM_RESP_STATE enum for the five FSM states.
- **Package reuse:** XLEN, DMEM_DEPTH_BYTES, DMEM_ADDR_WIDTH.
- **Sub-module friscv_mem_align:** purely combinational.
  - load_extract: rdata, addr[1:0], size, unsigned → formatted word.
  - store_merge: old word, wdata, addr[1:0], size → merged word.
  - Instantiated once; FSM and registers stay in the top module.

## Test plan
- Word store 0xDEADBEEF @0x010, then word load @0x010 → store response at T+2 with err=0; RAM write at word 4; load rsp_rdata_o=0xDEADBEEF at T+3.
- Byte store 0x80 @0x013 over 0x11223344, then LB @0x013 and LBU @0x013 → RAM word 0x80223344; LB = 0xFFFFFF80; LBU = 0x00000080.
- Half store 0xABCD @0x022 over 0, then LH @0x022 → RAM word 0xABCD0000; LH = 0xFFFFABCD.
- Half load @0x001, word store @0x006, size 11 @0x000 → each gives rsp_err_o=1 at T+1, rsp_rdata_o=0, ram_en_o never asserted.
- Four back-to-back loads with req_valid_i held high → each accepted in the previous RESP cycle; responses every 3 cycles, in order.
- rst_n low for one cycle during READ of a load → no rsp_valid_o; next cycle state is IDLE with all outputs at reset values; the following request completes normally.
